cmac_dot: RTL
=============

Name: cmac_dot

Overview:
- Parametrised complex multiply-accumulate unit for the SOML decoder datapath: successor to the single-product cmult.
- Streams LEN complex element pairs (a = row of H, b = column of S), one per accepted cycle.
- Produces the complex dot product sum(a*b), or sum(a*conj(b)) when `conj` is set, as one signed Q-format result with saturation flags.
- Valid/ready handshake on both input and output, so it can sit between the channel-matrix buffer and the metric stage.

Parameters:
- Q, 8, fractional bits of every operand and result (QN.Q two's complement).
- N, 16, total bits of ar/ai/br/bi/pr/pi.
- LEN, 4, elements per dot product; legal range 2..64.
- ACCW, 2*N+$clog2(LEN)+1, internal accumulator width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  element pair present on ar/ai/br/bi
- in_ready  out  1  block accepts element this cycle
- conj  in  1  sampled with the first element of a vector; 1 = use conj(b) for the whole vector
- ar, ai  in  N  signed real/imag of a
- br, bi  in  N  signed real/imag of b
- out_valid  out  1  result on pr/pi valid
- out_ready  in  1  downstream accepts result
- pr, pi  out  N  signed real/imag of result
- sat_r, sat_i  out  1  real/imag part clipped by saturation

Behaviour:
- Reset (async, any time including mid-vector or with result pending):
  - in_ready=1, out_valid=0, pr=pi=0, sat_r=sat_i=0.
  - Element count=0, state=ACC, pipeline valid flags cleared, partial sum discarded.
- Accept: an element is taken at a rising edge where in_valid && in_ready.
- States:
  - ACC: in_ready=1; count increments per accept; on the LEN-th accept go to DRAIN; in_ready drops after that edge.
  - DRAIN: in_ready=0; wait until the last element leaves the output stage; go to HOLD.
  - HOLD: out_valid=1, in_ready=0; pr/pi/sat stable until out_valid && out_ready at an edge, then go to ACC. in_ready=1 and out_valid=0 from the following cycle.
- Pipeline:
  - S1, registered at the accept edge: four full-width products ar*br, ai*bi, ar*bi, ai*br, each 2N bits signed, plus first/last flags and the conj latched on first.
  - S2, next edge:
    - re = ar*br - ai*bi, im = ar*bi + ai*br.
    - If conj: re = ar*br + ai*bi, im = ai*br - ar*bi.
    - Sign-extended to ACCW. First element loads the accumulator; later elements add to it. No explicit clear is needed.
  - S3, next edge after S2 processes last:
    - Arithmetic shift right of each accumulator part by Q (floor; no rounding).
    - Saturate to [-2^(N-1), 2^(N-1)-1]; the matching sat bit is set when clipping occurs.
    - Values are registered into pr/pi.
- Latency: out_valid=1 after the 3rd rising edge counting the LEN-th accept edge as the 1st.
- Gaps: in_valid may drop between elements; the count and partial sum hold.
- Products and accumulation are exact; quantisation happens only once, in S3.
- Back-to-back: no new vector is accepted while a result is held (one vector in flight).
- out_ready asserted before out_valid has no effect.
- Inputs are ignored when in_ready=0.

Test Plan:
- Directed vector, N=16, Q=8, LEN=4, conj=0:
  - Stimulus: ar={ffdd,0183,004d,0108}, ai={00c1,fff4,003c,fed8}, br={0080,ff80,0080,ff80}, bi=0, consecutive cycles.
  - Response: pr=16'hfecf (-305), pi=16'h0118 (280), sat_r=sat_i=0; out_valid 3 edges after the 4th accept.
- Conj mode:
  - Stimulus: four elements of a=(0100,0100), b=(0000,0100).
  - conj=0 gives pr=fc00, pi=0400; conj=1 gives pr=0400, pi=fc00.
- Saturation:
  - Stimulus: ar=br=7fff, ai=bi=0, ×4.
  - Response: pr=7fff, sat_r=1, pi=0000, sat_i=0.
  - Repeat with br=8001: pr=8000, sat_r=1.
- Handshake:
  - Stimulus: insert in_valid gaps of 0/1/3 cycles; hold out_ready=0 for 10 cycles.
  - Response: result unchanged vs gap-free run; pr/pi stable and in_ready=0 throughout the stall. Next vector accepted only after the out handshake.
- Reset:
  - Stimulus: assert rst after 2 of 4 elements, and again while in HOLD; then run the directed vector.
  - Response: outputs return to reset values immediately (asynchronously); the subsequent result is fecf/0118 with no residue.
- Back-to-back with out_ready tied 1:
  - Stimulus: two vectors streamed.
  - Response: second result correct; in_ready low from the LEN-th accept until the edge after the out handshake.

Source files
------------

// File: rtl/cmac_dot_if.sv
// Handshake and data bundle for the complex dot-product unit.
// The master side feeds element pairs and consumes results; the slave is cmac_dot.
interface cmac_dot_if #(
  parameter int N = 16
);
  logic                in_valid;
  logic                in_ready;
  logic                conj;
  logic signed [N-1:0] ar;
  logic signed [N-1:0] ai;
  logic signed [N-1:0] br;
  logic signed [N-1:0] bi;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] pr;
  logic signed [N-1:0] pi;
  logic                sat_r;
  logic                sat_i;

  modport master (
    output in_valid, conj, ar, ai, br, bi, out_ready,
    input  in_ready, out_valid, pr, pi, sat_r, sat_i
  );

  modport slave (
    input  in_valid, conj, ar, ai, br, bi, out_ready,
    output in_ready, out_valid, pr, pi, sat_r, sat_i
  );
endinterface

// File: rtl/cmac_dot.sv
// Complex multiply-accumulate: streams LEN element pairs and returns
// sum(a*b) or sum(a*conj(b)) as a saturated QN.Q complex result.
// Pipeline: S1 products, S2 exact accumulation, S3 shift/saturate to output.
module cmac_dot #(
  parameter int Q   = 8,
  parameter int N   = 16,
  parameter int LEN = 4
) (
  input logic        clk,
  input logic        rst,
  cmac_dot_if.slave  bus
);
  localparam int ACCW = 2*N + $clog2(LEN) + 1;
  localparam int CW   = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                accept;

  logic                s1_valid, s1_first, s1_last, s1_conj;
  logic signed [2*N-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [ACCW-1:0] e_rr, e_ii, e_ri, e_ir;
  logic signed [ACCW-1:0] re_t, im_t;
  logic signed [ACCW-1:0] acc_r, acc_i;
  logic                s2_last;
  logic signed [ACCW-1:0] sh_r, sh_i;
  logic [N:0]          clip_r, clip_i;

  assign accept        = bus.in_valid && in_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  // Returns {sat, value} after clipping to the N-bit signed range.
  function automatic logic [N:0] clip(input logic signed [ACCW-1:0] v);
    if (v > MAXV)      return {1'b1, MAXV[N-1:0]};
    else if (v < MINV) return {1'b1, MINV[N-1:0]};
    else               return {1'b0, v[N-1:0]};
  endfunction

  // Control FSM: element counting and the in/out handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACC;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (count == LAST) begin
              count      <= '0;
              in_ready_q <= 1'b0;
              state      <= DRAIN;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (s2_last) begin
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  // S1: full-width partial products plus position flags; conj is latched on the first element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_conj  <= 1'b0;
      p_rr     <= '0;
      p_ii     <= '0;
      p_ri     <= '0;
      p_ir     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        p_rr     <= bus.ar * bus.br;
        p_ii     <= bus.ai * bus.bi;
        p_ri     <= bus.ar * bus.bi;
        p_ir     <= bus.ai * bus.br;
        s1_first <= (count == '0);
        s1_last  <= (count == LAST);
        if (count == '0) s1_conj <= bus.conj;
      end
    end
  end

  assign e_rr = {{(ACCW-2*N){p_rr[2*N-1]}}, p_rr};
  assign e_ii = {{(ACCW-2*N){p_ii[2*N-1]}}, p_ii};
  assign e_ri = {{(ACCW-2*N){p_ri[2*N-1]}}, p_ri};
  assign e_ir = {{(ACCW-2*N){p_ir[2*N-1]}}, p_ir};

  // Combine products into the complex term for the selected mode.
  always_comb begin
    re_t = '0;
    im_t = '0;
    if (s1_conj) begin
      re_t = e_rr + e_ii;
      im_t = e_ir - e_ri;
    end else begin
      re_t = e_rr - e_ii;
      im_t = e_ri + e_ir;
    end
  end

  // S2: exact accumulation; the first element overwrites, so no clear is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= '0;
      acc_i   <= '0;
      s2_last <= 1'b0;
    end else begin
      s2_last <= s1_valid && s1_last;
      if (s1_valid) begin
        acc_r <= s1_first ? re_t : acc_r + re_t;
        acc_i <= s1_first ? im_t : acc_i + im_t;
      end
    end
  end

  assign sh_r   = acc_r >>> Q;
  assign sh_i   = acc_i >>> Q;
  assign clip_r = clip(sh_r);
  assign clip_i = clip(sh_i);

  // S3: single quantisation point; result held until the next vector completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pr    <= '0;
      bus.pi    <= '0;
      bus.sat_r <= 1'b0;
      bus.sat_i <= 1'b0;
    end else if (s2_last) begin
      bus.pr    <= clip_r[N-1:0];
      bus.pi    <= clip_i[N-1:0];
      bus.sat_r <= clip_r[N];
      bus.sat_i <= clip_i[N];
    end
  end
endmodule
